mbc_io_port: RTL and testbench
==============================

# mbc_io_port

Peripheral-side I/O interface for the basic computer. It sits on the far end of the CPU's output-data bus and input path. On the output direction it captures words the CPU drives during an OUT instruction into a small FIFO and presents them downstream with a valid/ready handshake. On the input direction it accepts bytes from an external producer into an input register (INPR) and raises the FGI flag until the CPU acknowledges with an INP instruction. It returns FGO/FGI to the control unit so that skip-on-flag instructions work.

## Interface
- d, 16, output data word width (matches CPU accumulator width)
- DEPTH, 4, output FIFO depth in words; power of two, ≥2
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low; clears all state
- out_strobe  in  1  CPU is executing OUT this cycle; cpu_data valid
- cpu_data  in  d  CPU output bus; high-Z/don't-care when out_strobe=0
- fgo  out  1  output flag: 1 = FIFO not full, CPU may issue OUT
- overflow  out  1  sticky: an OUT strobe was dropped because the FIFO was full
- count  out  log2(DEPTH)+1  words currently held in the FIFO
- tx_valid  out  1  FIFO head word available
- tx_data  out  d  FIFO head word
- tx_ready  in  1  downstream accepts head this cycle
- rx_valid  in  1  external producer offers a byte
- rx_data  in  8  offered byte
- rx_ready  out  1  port can accept a byte (= ~fgi)
- inpr  out  8  input register, read by the CPU on INP
- fgi  out  1  input flag: 1 = inpr holds an unread byte
- inp_ack  in  1  CPU executing INP this cycle; consumes inpr

## Operation
- The output FIFO is a circular buffer with write pointer, read pointer and occupancy count. full = (count==DEPTH); empty = (count==0).
- Push: out_strobe=1 and full=0 at the clock edge. cpu_data is written at the write pointer and the pointer increments mod DEPTH.
- Drop: out_strobe=1 and full=1. The word is discarded, state is unchanged and overflow is set to 1. Overflow stays 1 until reset.
- Pop: tx_valid=1 and tx_ready=1. The read pointer increments mod DEPTH.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Push while empty: no pop occurs in that cycle because tx_valid=0.
- Push while full: the push is dropped even if a pop happens in the same cycle, because full is evaluated on the registered count.
- tx_valid = ~empty. tx_data = entry at the read pointer (show-ahead). tx_data is held stable while tx_valid=1 and tx_ready=0.
- fgo = ~full, decoded combinationally from the registered count.
- Input side uses a two-state flag: EMPTY (fgi=0) and LOADED (fgi=1).
  - EMPTY → LOADED on rx_valid=1. inpr ← rx_data in the same edge.
  - LOADED → EMPTY on inp_ack=1.
  - inp_ack while EMPTY is ignored.
  - rx_valid while LOADED is not accepted (rx_ready=0); the producer must hold its byte.
  - inp_ack and rx_valid in the same LOADED cycle: the flag clears and the byte is not taken. The byte is accepted on the following cycle.
- inpr holds its value after acknowledgement and is only overwritten by the next accepted byte.

## Timing
- Reset (reset=0, asynchronous) forces the following immediately, independent of clk:
  - pointers=0, count=0
  - tx_valid=0, fgo=1, overflow=0
  - fgi=0, rx_ready=1, inpr=8'h00
  - FIFO storage contents are don't-care
- Reset asserted mid-transfer discards all queued words and any loaded byte. Operation resumes on the first rising edge after reset returns to 1.
- Push latency: a strobe at edge N gives tx_valid=1, the new count and the new fgo visible after edge N (one cycle).
- Pop latency: the next head appears after the accepting edge; there is no bubble between back-to-back pops.
- Input latency: a byte accepted at edge N gives fgi=1 and inpr valid after N. An ack at edge M gives fgi=0 and rx_ready=1 after M.
- All outputs are registered or decoded only from registered state. There is no combinational path from tx_ready, out_strobe, rx_valid or inp_ack to any output.
- count wraps never. Pointers wrap from DEPTH-1 to 0.

## Test plan
- Reset check: drive reset=0, then release → fgo=1, tx_valid=0, count=0, fgi=0, rx_ready=1, inpr=00, overflow=0.
- Fill and drain: with tx_ready=0, strobe 16'h0A01..16'h0A04 on 4 consecutive cycles → count=4, fgo=0. Then hold tx_ready=1 → tx_data is 0A01, 0A02, 0A03, 0A04 on consecutive cycles, then tx_valid=0, fgo=1.
- Overflow: with the FIFO full, strobe 16'hDEAD while tx_ready=1 → DEAD is never output, overflow=1, count=3 next cycle. Overflow stays 1 until reset.
- Concurrent push/pop: count=2, strobe 16'h1234 with tx_ready=1 → count stays 2, pointers wrap past DEPTH-1 correctly, and 1234 emerges third.
- Input handshake: rx_valid=1, rx_data=8'h5A → fgi=1, inpr=5A, rx_ready=0. Offer 8'hC3 with inp_ack=1 in the same cycle → fgi=0, inpr=5A. Next cycle C3 is accepted → inpr=C3, fgi=1.
- Async reset mid-operation: count=3, fgi=1, pull reset low between clock edges → outputs reach reset values before the next edge, and no stale word appears after release.

Source files
------------

// File: rtl/mbc_io_port.sv
// ============================================================================
// Module   : mbc_io_port
// Purpose  : Peripheral I/O port: OUT-word FIFO with valid/ready drain, plus
//            an INPR byte register guarded by the FGI flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbc_io_port #(
    parameter int D     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     out_strobe,
    input  logic [D-1:0]             cpu_data,
    output logic                     fgo,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_valid,
    output logic [D-1:0]             tx_data,
    input  logic                     tx_ready,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     rx_ready,
    output logic [7:0]               inpr,
    output logic                     fgi,
    input  logic                     inp_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {
        IN_EMPTY  = 1'b0,
        IN_LOADED = 1'b1
    } in_state_t;

    logic [D-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    in_state_t     in_state;
    in_state_t     in_state_next;
    logic          load_byte;

    // Flags come only from registered count, so a same-cycle pop cannot rescue a push into a full FIFO.
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign push     = out_strobe & ~full;
    assign pop      = ~empty & tx_ready;

    assign fgo      = ~full;
    assign tx_valid = ~empty;
    assign tx_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (out_strobe && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state <= IN_EMPTY;
            inpr     <= 8'h00;
        end else begin
            in_state <= in_state_next;
            if (load_byte) begin
                inpr <= rx_data;
            end
        end
    end

    // An ack in LOADED wins over a pending offer; the byte is taken next cycle.
    always_comb begin
        in_state_next = in_state;
        load_byte     = 1'b0;
        case (in_state)
            IN_EMPTY: begin
                if (rx_valid) begin
                    in_state_next = IN_LOADED;
                    load_byte     = 1'b1;
                end
            end
            IN_LOADED: begin
                if (inp_ack) begin
                    in_state_next = IN_EMPTY;
                end
            end
            default: in_state_next = IN_EMPTY;
        endcase
    end

    assign fgi      = (in_state == IN_LOADED);
    assign rx_ready = ~fgi;

endmodule

`default_nettype wire

// File: tb/tb_mbc_io_port.sv
// ============================================================================
// Module   : tb_mbc_io_port
// Purpose  : Scoreboard bench for mbc_io_port; a negedge monitor pops expected
//            words whenever the DUT hands one off.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mbc_io_port;

    logic        clk;
    logic        reset;
    logic        out_strobe;
    logic [15:0] cpu_data;
    logic        fgo;
    logic        overflow;
    logic [2:0]  count;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  inpr;
    logic        fgi;
    logic        inp_ack;

    int          n_pass;
    int          n_total;
    logic [15:0] exp_q[$];

    mbc_io_port #(.D(16), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .out_strobe (out_strobe),
        .cpu_data   (cpu_data),
        .fgo        (fgo),
        .overflow   (overflow),
        .count      (count),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .inpr       (inpr),
        .fgi        (fgi),
        .inp_ack    (inp_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"},    32'(count),    32'd0);
        chk({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, " fgo"},      32'(fgo),      32'd1);
        chk({tag, " overflow"}, 32'(overflow), 32'd0);
        chk({tag, " fgi"},      32'(fgi),      32'd0);
        chk({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, " inpr"},     32'(inpr),     32'h00);
    endtask

    // Monitor: every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL tx_word: got %0h expected none", tx_data);
            end else begin
                chk("tx_word", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset      = 1'b0;
        out_strobe = 1'b0;
        cpu_data   = 16'h0;
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        inp_ack    = 1'b0;

        #2;
        chk_reset_vals("rst_hold");
        cyc();
        #3 reset = 1'b1;
        cyc();
        chk_reset_vals("rst_rel");

        // Fill to full with the drain stalled.
        for (int i = 0; i < 4; i++) begin
            out_strobe = 1'b1;
            cpu_data   = 16'h0A01 + 16'(i);
            exp_q.push_back(cpu_data);
            cyc();
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        out_strobe = 1'b0;
        chk("full_fgo", 32'(fgo), 32'd0);
        chk("full_valid", 32'(tx_valid), 32'd1);
        chk("full_ovf", 32'(overflow), 32'd0);

        // Strobe while full with a pop in the same cycle: word dropped.
        out_strobe = 1'b1;
        cpu_data   = 16'hDEAD;
        tx_ready   = 1'b1;
        cyc();
        out_strobe = 1'b0;
        chk("drop_count", 32'(count), 32'd3);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_fgo", 32'(fgo), 32'd1);
        for (int i = 2; i >= 0; i--) begin
            cyc();
            chk("drain_count", 32'(count), 32'(i));
        end
        chk("drain_valid", 32'(tx_valid), 32'd0);
        chk("drain_fgo", 32'(fgo), 32'd1);
        chk("drain_q", 32'(exp_q.size()), 32'd0);

        // Concurrent push/pop with pointer wrap.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            out_strobe = 1'b1;
            cpu_data   = 16'h1111 * 16'(i + 1);
            exp_q.push_back(cpu_data);
            cyc();
        end
        out_strobe = 1'b0;
        tx_ready   = 1'b1;
        cyc();
        chk("cc_pre_count", 32'(count), 32'd2);
        out_strobe = 1'b1;
        cpu_data   = 16'h4444;
        exp_q.push_back(cpu_data);
        cyc();
        chk("cc_count_a", 32'(count), 32'd2);
        cpu_data   = 16'h1234;
        exp_q.push_back(cpu_data);
        cyc();
        chk("cc_count_b", 32'(count), 32'd2);
        out_strobe = 1'b0;
        cyc();
        cyc();
        chk("cc_empty", 32'(tx_valid), 32'd0);
        chk("cc_q", 32'(exp_q.size()), 32'd0);
        tx_ready = 1'b0;

        // Input handshake.
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        cyc();
        chk("in_fgi1", 32'(fgi), 32'd1);
        chk("in_inpr1", 32'(inpr), 32'h5A);
        chk("in_rdy1", 32'(rx_ready), 32'd0);
        rx_data = 8'hC3;
        inp_ack = 1'b1;
        cyc();
        chk("in_fgi2", 32'(fgi), 32'd0);
        chk("in_inpr2", 32'(inpr), 32'h5A);
        chk("in_rdy2", 32'(rx_ready), 32'd1);
        inp_ack = 1'b0;
        cyc();
        chk("in_fgi3", 32'(fgi), 32'd1);
        chk("in_inpr3", 32'(inpr), 32'hC3);
        rx_valid = 1'b0;
        inp_ack  = 1'b1;
        cyc();
        cyc();
        chk("in_ack_empty", 32'(fgi), 32'd0);
        chk("in_hold", 32'(inpr), 32'hC3);
        inp_ack = 1'b0;
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Async reset mid-operation.
        for (int i = 0; i < 3; i++) begin
            out_strobe = 1'b1;
            cpu_data   = 16'h7700 + 16'(i);
            cyc();
        end
        out_strobe = 1'b0;
        rx_valid   = 1'b1;
        rx_data    = 8'h77;
        cyc();
        rx_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_fgi", 32'(fgi), 32'd1);
        #3 reset = 1'b0;
        #1;
        chk_reset_vals("async");
        cyc();
        #3 reset = 1'b1;
        tx_ready = 1'b1;
        cyc();
        cyc();
        chk("post_rst_valid", 32'(tx_valid), 32'd0);
        out_strobe = 1'b1;
        cpu_data   = 16'hBEEF;
        exp_q.push_back(cpu_data);
        cyc();
        out_strobe = 1'b0;
        chk("post_rst_count", 32'(count), 32'd1);
        cyc();
        cyc();
        chk("final_q", 32'(exp_q.size()), 32'd0);
        chk("final_valid", 32'(tx_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
